// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer that time-shares the EX-stage 32-bit ALU (shift-add / restoring divide).
// Optional signed MULT/DIV via `define MULDIV_SIGNED_EN (adds a one-cycle FIX state for sign correction).
module alu_muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dado_1,
   input  logic [WIDTH-1:0] dado_2,
   output logic [WIDTH-1:0] alu_dado_1,
   output logic [WIDTH-1:0] alu_dado_2,
   output logic [3:0]       alu_ALUControl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
   logic             is_div_q, is_div_d, dz_q, dz_d;
`ifdef MULDIV_SIGNED_EN
   logic             sgn_q, sgn_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic             a_neg, b_neg;
   logic [2*WIDTH-1:0] prod_neg;
`endif
   logic [WIDTH-1:0] a_mag, b_mag, sum;
   logic             carry;

   // Divide step operands: {t, rem_s, quot_s} = {hi, lo} << 1
   logic             t;
   logic [WIDTH-1:0] rem_s, quot_s;
   assign t      = hi_q[WIDTH-1];
   assign rem_s  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
   assign quot_s = {lo_q[WIDTH-2:0], 1'b0};

   logic [1:0] unused_in;
   assign unused_in = {alu_zero, op[1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         is_div_q <= 1'b0;
         dz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         sgn_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mcand_q  <= mcand_d;
         is_div_q <= is_div_d;
         dz_q     <= dz_d;
`ifdef MULDIV_SIGNED_EN
         sgn_q    <= sgn_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      hi_d           = hi_q;
      lo_d           = lo_q;
      mcand_d        = mcand_q;
      is_div_d       = is_div_q;
      dz_d           = dz_q;
      alu_dado_1     = '0;
      alu_dado_2     = '0;
      alu_ALUControl = 4'd0;
      sum            = hi_q;
      carry          = 1'b0;
      a_mag          = dado_1;
      b_mag          = dado_2;
`ifdef MULDIV_SIGNED_EN
      sgn_d          = sgn_q;
      neg_lo_d       = neg_lo_q;
      neg_hi_d       = neg_hi_q;
      a_neg          = op[1] & dado_1[WIDTH-1];
      b_neg          = op[1] & dado_2[WIDTH-1];
      prod_neg       = -{hi_q, lo_q};
      if (a_neg) a_mag = -dado_1;
      if (b_neg) b_mag = -dado_2;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d    = '0;
               hi_d     = '0;
               is_div_d = op[0];
               dz_d     = 1'b0;
`ifdef MULDIV_SIGNED_EN
               sgn_d    = op[1];
               neg_lo_d = a_neg ^ b_neg;
               neg_hi_d = op[0] ? a_neg : (a_neg ^ b_neg);
`endif
               if (op[0] && (dado_2 == '0)) begin
                  // Divide by zero skips the core; hi keeps the raw dividend
                  state_d = S_DONE;
                  hi_d    = dado_1;
                  lo_d    = '1;
                  dz_d    = 1'b1;
               end else begin
                  state_d = S_RUN;
                  lo_d    = op[0] ? a_mag : b_mag;
                  mcand_d = op[0] ? b_mag : a_mag;
               end
            end
         end
         S_RUN: begin
            alu_dado_2 = mcand_q;
            if (is_div_q) begin
               alu_dado_1     = rem_s;
               alu_ALUControl = 4'd6;
               if (t || (rem_s >= mcand_q)) begin
                  hi_d = alu_result;
                  lo_d = {quot_s[WIDTH-1:1], 1'b1};
               end else begin
                  hi_d = rem_s;
                  lo_d = quot_s;
               end
            end else begin
               alu_dado_1     = hi_q;
               alu_ALUControl = 4'd2;
               if (lo_q[0]) begin
                  sum   = alu_result;
                  carry = (alu_result < hi_q);
               end
               hi_d = {carry, sum[WIDTH-1:1]};
               lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) begin
`ifdef MULDIV_SIGNED_EN
               state_d = sgn_q ? S_FIX : S_DONE;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef MULDIV_SIGNED_EN
         S_FIX: begin
            if (is_div_q) begin
               if (neg_lo_q) lo_d = -lo_q;
               if (neg_hi_q) hi_d = -hi_q;
            end else if (neg_lo_q) begin
               {hi_d, lo_d} = prod_neg;
            end
            state_d = S_DONE;
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
            dz_d    = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q == S_RUN) || (state_q == S_FIX);
   assign done      = (state_q == S_DONE);
   assign div_zero  = dz_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed test-plan cases plus random ops against an arithmetic reference.
// Includes a behavioural ALU; signed cases are active when MULDIV_SIGNED_EN is defined.
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [1:0]  op;
   logic [31:0] dado_1, dado_2, alu_dado_1, alu_dado_2, alu_result, hi, lo;
   logic [3:0]  alu_ALUControl;
   logic        alu_zero, busy, done, div_zero;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   alu_muldiv_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .dado_1(dado_1), .dado_2(dado_2),
      .alu_dado_1(alu_dado_1), .alu_dado_2(alu_dado_2), .alu_ALUControl(alu_ALUControl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Behavioural ALUCentral
   always_comb begin
      case (alu_ALUControl)
         4'd2:    alu_result = alu_dado_1 + alu_dado_2;
         4'd6:    alu_result = alu_dado_1 - alu_dado_2;
         default: alu_result = alu_dado_1 & alu_dado_2;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural operands
   task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic dz, output int lat);
      longint     sa, sb, q, r;
      logic [63:0] p;
      bit         sgn;
      sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn = o[1];
`endif
      dz  = 1'b0;
      lat = 33;
      if (o[0] && b == 32'd0) begin
         h = a; l = 32'hFFFF_FFFF; dz = 1'b1; lat = 1;
      end else if (sgn) begin
         lat = 34;
         sa  = longint'($signed(a));
         sb  = longint'($signed(b));
         if (!o[0]) begin
            p = sa * sb; h = p[63:32]; l = p[31:0];
         end else begin
            q = sa / sb; r = sa % sb;
            l = q[31:0]; h = r[31:0];
         end
      end else if (!o[0]) begin
         p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0];
      end else begin
         l = a / b; h = a % b;
      end
   endtask

   // Issue one op; optionally pulse a stray start (divide-by-zero request) in cycle poke_cyc
   task automatic run_op(input logic [1:0] op_v, input logic [31:0] a, input logic [31:0] b,
                         input int poke_cyc);
      logic [31:0] e_hi, e_lo;
      logic        e_dz;
      int          e_lat, n;
      logic [3:0]  e_ctrl;
      bit          ctrl_ok, busy_ok;
      model(op_v, a, b, e_hi, e_lo, e_dz, e_lat);
      e_ctrl = op_v[0] ? 4'd6 : 4'd2;
      @(negedge clk);
      start = 1'b1; op = op_v; dado_1 = a; dado_2 = b;
      @(negedge clk);
      start = 1'b0; dado_1 = $urandom; dado_2 = $urandom;
      n = 1; ctrl_ok = 1'b1; busy_ok = 1'b1;
      while (!done && n < 40) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (n <= 32 ? (alu_ALUControl !== e_ctrl) : (alu_ALUControl !== 4'd0)) ctrl_ok = 1'b0;
         if (n == poke_cyc) begin
            start = 1'b1; op = 2'b01; dado_1 = 32'd7; dado_2 = 32'd0;
         end
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      check("latency", 64'(n), 64'(e_lat));
      if (e_lat > 1) begin
         check("busy_during_run", 64'(busy_ok), 64'd1);
         check("alu_ctrl_during_run", 64'(ctrl_ok), 64'd1);
      end
      check("busy_at_done", 64'(busy), 64'd0);
      check("ctrl_at_done", 64'(alu_ALUControl), 64'd0);
      check("hi", 64'(hi), 64'(e_hi));
      check("lo", 64'(lo), 64'(e_lo));
      check("div_zero", 64'(div_zero), 64'(e_dz));
      @(negedge clk);
      check("done_pulse_one_cycle", 64'(done), 64'd0);
      check("div_zero_cleared", 64'(div_zero), 64'd0);
      check("hi_hold", 64'(hi), 64'(e_hi));
      check("lo_hold", 64'(lo), 64'(e_lo));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          seen_done;
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      reset = 1'b1; start = 1'b0; op = 2'b00; dado_1 = 32'd0; dado_2 = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_div_zero", 64'(div_zero), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_alu_d1", 64'(alu_dado_1), 64'd0);
      check("rst_alu_d2", 64'(alu_dado_2), 64'd0);
      check("rst_alu_ctrl", 64'(alu_ALUControl), 64'd0);
      reset = 1'b0;

      run_op(2'b00, 32'd3, 32'd3, 0);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(2'b01, 32'd100, 32'd7, 0);
      run_op(2'b01, 32'd5, 32'd0, 0);
      run_op(2'b00, 32'd2, 32'd2, 5);
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(2'b01, 32'h8000_0001, 32'hFFFF_FFFF, 0);
`ifdef MULDIV_SIGNED_EN
      run_op(2'b10, 32'hFFFF_FFFD, 32'd3, 0);
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(2'b11, 32'd7, 32'hFFFF_FFFE, 0);
      run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 0);
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
`else
      run_op(2'b10, 32'hFFFF_FFFD, 32'd3, 0);
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
`endif

      // Reset in cycle 10 of a multiply aborts it with no result
      @(negedge clk);
      start = 1'b1; op = 2'b00; dado_1 = 32'd2; dado_2 = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      check("abort_alu_ctrl", 64'(alu_ALUControl), 64'd0);
      seen_done = 1'b0;
      repeat (40) begin
         if (done) seen_done = 1'b1;
         @(negedge clk);
      end
      check("abort_no_done", 64'(seen_done), 64'd0);

      // Random ops; small operands and zero divisors mixed in
      for (int i = 0; i < 24; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
         r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         run_op(r_op, r_a, r_b, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 32)) : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer that executes MULTU/DIVU by time-sharing the existing 32-bit ALUCentral.
- Drives the ALU's operand and control inputs for 32 iterations and consumes ALUResult.
- Sits beside the ALU in the EX stage; the pipeline stalls on busy and reads hi/lo at done.

Parameters:
- WIDTH, 32, operand width; only 32 is supported, since the ALU is 32-bit.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV; op[1] is meaningful only with MULDIV_SIGNED_EN.
- dado_1  in  32  multiplicand / dividend.
- dado_2  in  32  multiplier / divisor.
- alu_dado_1  out  32  to ALU dado_1.
- alu_dado_2  out  32  to ALU dado_2.
- alu_ALUControl  out  4  to ALU; 2 = add, 6 = sub, 0 = AND (idle).
- alu_result  in  32  from ALU ALUResult.
- alu_zero  in  1  from ALU zero; unused internally, reserved.
- busy  out  1  high from the start-accept cycle until done.
- done  out  1  one-cycle pulse; hi/lo valid from this cycle.
- div_zero  out  1  high with done when a divide had dado_2 == 0.
- hi  out  32  product[63:32] / remainder.
- lo  out  32  product[31:0] / quotient.

Behaviour:
- Reset, synchronous and active-high: state = IDLE. busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, alu_dado_1 = 0, alu_dado_2 = 0, alu_ALUControl = 0. Reset asserted mid-operation aborts immediately with the same values; there is no partial result.
- States: IDLE, RUN, DONE (plus FIX when the optional feature is enabled).
- IDLE:
  - start = 1 latches the operands and op and moves to RUN. Iteration counter = 0, busy = 1.
  - For DIVU with dado_2 == 0, go straight to DONE instead: hi = dado_1, lo = 32'hFFFFFFFF, div_zero = 1.
- start while busy or DONE: ignored, with no queuing.
- RUN, multiply (shift-add):
  - State is {c, hi, lo}, with lo = multiplier and hi = 0 at accept.
  - Each cycle: alu_dado_1 = hi, alu_dado_2 = mcand, alu_ALUControl = 2.
  - If lo[0]: sum = alu_result and c = (alu_result < hi), an unsigned compare done locally. Otherwise sum = hi and c = 0.
  - {hi, lo} <= {c, sum, lo} >> 1.
- RUN, divide (restoring):
  - rem = hi (init 0), quot = lo (init dividend).
  - Shift {t, rem_s, quot_s} = {rem, quot} << 1.
  - Each cycle: alu_dado_1 = rem_s, alu_dado_2 = divisor, alu_ALUControl = 6.
  - If t or (rem_s >= divisor): hi = alu_result, lo = {quot_s[31:1], 1}. Otherwise hi = rem_s, lo = {quot_s[31:1], 0}.
- Counter: after iteration 31, go to DONE.
- Latency: start accepted in cycle 0; iterations run in cycles 1..32; done = 1 in cycle 33. The divide-by-zero path raises done in cycle 1.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle, then IDLE.
  - hi/lo hold their value until the next accepted start.
  - div_zero clears when the state leaves DONE.
- ALU outputs outside RUN: alu_dado_1 = alu_dado_2 = 0, alu_ALUControl = 0.
- All arithmetic is unsigned modulo 2^32 per ALU pass; carry and borrow are derived locally as stated, never from alu_zero.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - op 10/11 run signed MULT/DIV. Operands are converted to magnitudes at accept and the unsigned core runs unchanged.
  - A FIX state of 1 cycle between RUN and DONE negates the results locally. Product is negated if signs differ; quotient is negated if signs differ; remainder takes the dividend's sign.
  - Signed latency: done in cycle 34.
  - Signed divide by zero uses the same path as DIVU: hi = dado_1, lo = 32'hFFFFFFFF, div_zero = 1, done in cycle 1.
- Undefined: op[1] is ignored; all ops are unsigned; FIX is absent.

Test Plan:
- MULTU 3 x 3, start in cycle 0 -> done in cycle 33, hi = 0, lo = 9; alu_ALUControl = 2 throughout cycles 1..32.
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi = 32'hFFFFFFFE, lo = 32'h00000001 (exercises carry-out).
- DIVU 100 / 7 -> done in cycle 33, lo = 14, hi = 2, div_zero = 0; alu_ALUControl = 6 during RUN.
- DIVU 5 / 0 -> done in cycle 1, div_zero = 1, hi = 5, lo = 32'hFFFFFFFF.
- MULTU 2 x 2, second start pulsed in cycle 5 -> ignored and done in cycle 33 with lo = 4. Repeat with reset in cycle 10 -> cycle 11 shows busy = 0, hi = lo = 0, and done never pulses.
- MULDIV_SIGNED_EN, MULT -3 x 3 -> done in cycle 34, hi = 32'hFFFFFFFF, lo = 32'hFFFFFFF7. Signed DIV -7 / 2 -> lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF.
